// File: rtl/cam_pkg.sv
// Definitions shared by the camera capture stage and the VGA display stage.
package cam_pkg;

    typedef enum logic [1:0] {
        StWaitFrame = 2'd0,
        StSkip      = 2'd1,
        StCapture   = 2'd2,
        StDrop      = 2'd3
    } cam_state_t;

    localparam int unsigned HActiveDef    = 640;
    localparam int unsigned VActiveDef    = 480;
    localparam int unsigned SkipFramesDef = 2;

    // RGB565 field positions within a 16-bit pixel word.
    localparam int unsigned RedMsb = 15;
    localparam int unsigned RedLsb = 11;
    localparam int unsigned GrnMsb = 10;
    localparam int unsigned GrnLsb = 5;
    localparam int unsigned BluMsb = 4;
    localparam int unsigned BluLsb = 0;

    function automatic logic [15:0] pack_rgb565(input logic [7:0] hi, input logic [7:0] lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/cam_capture_if.sv
// Camera byte port plus FIFO write side, as seen by the capture stage (master).
interface cam_capture_if;

    logic        cam_vsync;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic        full_fifo;
    logic        wr_en;
    logic [15:0] dout;

    modport master (
        input  cam_vsync, cam_href, cam_data, full_fifo,
        output wr_en, dout
    );

    modport slave (
        output cam_vsync, cam_href, cam_data, full_fifo,
        input  wr_en, dout
    );

endinterface

// File: rtl/sync_edge_det.sv
// Registers one input and compares against a delayed copy to form edge pulses.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic sig_o,
    output logic rise_o,
    output logic fall_o
);

    logic sig_q;
    logic dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= 1'b0;
            dly_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
            dly_q <= sig_q;
        end
    end

    assign sig_o  = sig_q;
    assign rise_o = sig_q & ~dly_q;
    assign fall_o = ~sig_q & dly_q;

endmodule

// File: rtl/cam_capture.sv
// Frames the camera byte stream with VSYNC/HREF and writes RGB565 words to the pixel FIFO.
module cam_capture
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = HActiveDef,
    parameter int unsigned V_ACTIVE    = VActiveDef,
    parameter int unsigned SKIP_FRAMES = SkipFramesDef
) (
    input  logic          clk,
    input  logic          rst,
    cam_capture_if.master bus,
    output logic          frame_done,
    output logic          overflow,
    output logic [7:0]    frame_count
);

    localparam logic [9:0] XLim    = 10'(H_ACTIVE);
    localparam logic [8:0] YLim    = 9'(V_ACTIVE);
    localparam logic [7:0] SkipLim = 8'(SKIP_FRAMES);

    cam_state_t state_q;
    logic [7:0] skip_q;
    logic [9:0] x_q;
    logic [8:0] y_q;
    logic       phase_q;
    logic [7:0] hi_q;
    logic [7:0] data_q;

    logic vsync_r, vsync_rise, vsync_fall;
    logic href_r, href_rise, href_fall;
    logic       cur_phase;
    logic [9:0] cur_x;
    logic       word_done;
    logic       in_window;

    sync_edge_det u_vsync (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (bus.cam_vsync),
        .sig_o  (vsync_r),
        .rise_o (vsync_rise),
        .fall_o (vsync_fall)
    );

    sync_edge_det u_href (
        .clk    (clk),
        .rst    (rst),
        .sig_i  (bus.cam_href),
        .sig_o  (href_r),
        .rise_o (href_rise),
        .fall_o (href_fall)
    );

    // The first byte of a line is always a high byte, whatever phase the last line left behind.
    always_comb begin
        cur_phase = href_rise ? 1'b0 : phase_q;
        cur_x     = href_rise ? 10'd0 : x_q;
        word_done = href_r & cur_phase & ~vsync_r;
        in_window = (cur_x < XLim) && (y_q < YLim);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StWaitFrame;
            skip_q      <= 8'd0;
            x_q         <= 10'd0;
            y_q         <= 9'd0;
            phase_q     <= 1'b0;
            hi_q        <= 8'd0;
            data_q      <= 8'd0;
            bus.wr_en   <= 1'b0;
            bus.dout    <= 16'd0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            data_q     <= bus.cam_data;
            bus.wr_en  <= 1'b0;
            frame_done <= 1'b0;

            phase_q <= href_r ? ~cur_phase : cur_phase;
            if (href_r && !cur_phase) begin
                hi_q <= data_q;
            end
            if (word_done && cur_x != '1) begin
                x_q <= cur_x + 10'd1;
            end else begin
                x_q <= cur_x;
            end

            unique case (state_q)
                StWaitFrame: begin
                    if (vsync_fall) begin
                        if (skip_q < SkipLim) begin
                            state_q <= StSkip;
                        end else begin
                            state_q <= StCapture;
                            y_q     <= 9'd0;
                        end
                    end
                end
                StSkip: begin
                    if (vsync_rise) begin
                        skip_q  <= skip_q + 8'd1;
                        state_q <= StWaitFrame;
                    end
                end
                StCapture: begin
                    // Frame end takes priority over a colliding word or a full FIFO.
                    if (vsync_rise) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                        state_q     <= StWaitFrame;
                    end else begin
                        if (href_fall && y_q != '1) begin
                            y_q <= y_q + 9'd1;
                        end
                        if (word_done && in_window) begin
                            if (bus.full_fifo) begin
                                overflow <= 1'b1;
                                state_q  <= StDrop;
                            end else begin
                                bus.wr_en <= 1'b1;
                                bus.dout  <= pack_rgb565(hi_q, data_q);
                            end
                        end
                    end
                end
                StDrop: begin
                    if (vsync_rise) begin
                        state_q <= StWaitFrame;
                    end
                end
                default: state_q <= StWaitFrame;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
// Random-data frame bench for cam_capture with a word-list reference model built from the framing rules.
module tb_cam_capture;
    import cam_pkg::*;

    localparam int H = 6;
    localparam int V = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_done;
    logic       overflow;
    logic [7:0] frame_count;

    cam_capture_if bus ();

    cam_capture #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .SKIP_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observation side: every written word and every frame_done cycle.
    logic [15:0] obs[$];
    int          done_n   = 0;
    int          consec_n = 0;
    logic        prev_wr  = 1'b0;

    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            obs.push_back(bus.dout);
            if (prev_wr === 1'b1) consec_n <= consec_n + 1;
        end
        if (frame_done === 1'b1) done_n <= done_n + 1;
        prev_wr <= bus.wr_en;
    end

    // Reference model state.
    logic [15:0] exp[$];
    int          frame_ord;
    bit          cap_on;
    bit          dropped;
    bit          exp_ovf;
    int          line_y;
    int          frame_word;
    int          exp_done;
    logic [7:0]  exp_cnt;
    int          done_base;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_wr_en"}, 32'(bus.wr_en), 32'd0);
        chk({tag, "_dout"}, 32'(bus.dout), 32'd0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        chk({tag, "_overflow"}, 32'(overflow), 32'd0);
        chk({tag, "_frame_count"}, 32'(frame_count), 32'd0);
    endtask

    task automatic check_frame(input string tag);
        int bad;
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_nwr"}, obs.size(), exp.size());
        bad = -1;
        for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
            if (bad < 0 && obs[i] !== exp[i]) bad = i;
        end
        checks++;
        assert (bad < 0) else begin
            errors++;
            $error("FAIL %s_word: idx %0d got %h want %h", tag, bad, obs[bad], exp[bad]);
        end
        chk({tag, "_done"}, done_n, exp_done);
        chk({tag, "_count"}, 32'(frame_count), 32'(exp_cnt));
        chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
    endtask

    // Closes the current frame with a vsync pulse and opens the next one.
    task automatic vsync_pulse(input string tag);
        if (cap_on && !dropped) begin
            exp_done++;
            exp_cnt++;
        end
        @(negedge clk);
        bus.cam_vsync = 1'b1;
        repeat (3) @(negedge clk);
        bus.cam_vsync = 1'b0;
        repeat (3) @(negedge clk);
        frame_ord++;
        cap_on     = (frame_ord > 2);
        dropped    = 1'b0;
        line_y     = 0;
        frame_word = 0;
        check_frame(tag);
    endtask

    task automatic send_line(input int nbytes, input int full_at, input bit magenta);
        logic [7:0] b;
        logic [7:0] hi;
        hi = 8'h00;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk);
            if (magenta && i == 2) chk("lat_early", 32'(bus.wr_en), 32'd0);
            if (magenta && i == 3) begin
                chk("lat_wr", 32'(bus.wr_en), 32'd1);
                chk("lat_dout", 32'(bus.dout), 32'hF81F);
                chk("red", 32'(bus.dout[RedMsb:RedLsb]), 32'h1F);
                chk("grn", 32'(bus.dout[GrnMsb:GrnLsb]), 32'h00);
                chk("blu", 32'(bus.dout[BluMsb:BluLsb]), 32'h1F);
            end
            if (magenta && i == 4) begin
                chk("hold_wr", 32'(bus.wr_en), 32'd0);
                chk("hold_dout", 32'(bus.dout), 32'hF81F);
            end
            b = 8'($urandom);
            if (magenta && i == 0) b = 8'hF8;
            if (magenta && i == 1) b = 8'h1F;
            bus.cam_href = 1'b1;
            bus.cam_data = b;
            if (i % 2 == 0) begin
                hi = b;
            end else if (cap_on && !dropped && line_y < V && i / 2 < H) begin
                if (frame_word == full_at) begin
                    bus.full_fifo = 1'b1;
                    dropped       = 1'b1;
                    exp_ovf       = 1'b1;
                end else begin
                    exp.push_back({hi, b});
                end
                frame_word++;
            end
        end
        @(negedge clk);
        bus.cam_href = 1'b0;
        bus.cam_data = 8'($urandom);
        @(negedge clk);
        bus.full_fifo = 1'b0;
        @(negedge clk);
        line_y++;
    endtask

    task automatic send_frame(input int full_at);
        for (int l = 0; l < V; l++) send_line(2 * H, full_at, 1'b0);
    endtask

    task automatic model_reset();
        frame_ord  = 0;
        cap_on     = 1'b0;
        dropped    = 1'b0;
        exp_ovf    = 1'b0;
        line_y     = 0;
        frame_word = 0;
        exp_cnt    = 8'd0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.cam_vsync = 1'b0;
        bus.cam_href  = 1'b0;
        bus.cam_data  = 8'h00;
        bus.full_fifo = 1'b0;
        rst           = 1'b1;
        exp_done      = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("rst0");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Two settling frames, then one captured frame.
        vsync_pulse("open1");
        send_frame(-1);
        vsync_pulse("skip1");
        send_frame(-1);
        vsync_pulse("skip2");
        send_frame(-1);
        vsync_pulse("cap3");

        // Magenta latency, long line, odd trailing byte, and an extra line.
        send_line(2 * H, -1, 1'b1);
        send_line(2 * H + 4, -1, 1'b0);
        send_line(2 * H + 1, -1, 1'b0);
        send_line(2 * H, -1, 1'b0);
        send_line(2 * H, -1, 1'b0);
        vsync_pulse("edges4");

        send_frame(10);
        vsync_pulse("full5");
        send_frame(-1);
        vsync_pulse("after6");

        // Reset between lines of a captured frame.
        send_line(2 * H, -1, 1'b0);
        send_line(2 * H, -1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset("rst_mid");
        done_base = done_n;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        send_line(2 * H, -1, 1'b0);
        send_line(2 * H, -1, 1'b0);
        vsync_pulse("rs_open");
        send_frame(-1);
        vsync_pulse("rs_skip1");
        send_frame(-1);
        vsync_pulse("rs_skip2");
        send_frame(-1);
        vsync_pulse("rs_cap");

        for (int f = 0; f < 255; f++) begin
            send_frame(-1);
            vsync_pulse("wrap");
        end
        chk("wrap_count", 32'(frame_count), 32'd0);
        chk("wrap_done", done_n - done_base, 32'd256);
        chk("no_b2b_wr", consec_n, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cam_capture.md
# cam_capture

Pixel-capture stage between the OV7670-style camera port and the write side of the asynchronous pixel FIFO that the VGA display stage drains. It runs on the camera pixel clock, frames the incoming byte stream using VSYNC/HREF, and packs byte pairs into RGB565 words. It writes exactly one 640x480 frame's worth of words per frame and stops writing for the rest of any frame in which the FIFO fills.

## Interface
- `H_ACTIVE`, 640: words accepted per line; extra pixels on a line are ignored.
- `V_ACTIVE`, 480: lines accepted per frame; extra lines are ignored.
- `SKIP_FRAMES`, 2: complete frames discarded after reset while camera registers settle.
- `clk` in 1: camera pixel clock (PCLK); sole clock.
- `rst` in 1: synchronous, active-high reset.
- `cam_vsync` in 1: high during vertical blanking.
- `cam_href` in 1: high while line bytes are valid.
- `cam_data` in 8: pixel byte.
- `full_fifo` in 1: FIFO write-side full.
- `wr_en` out 1: one-cycle FIFO write strobe.
- `dout` out 16: RGB565 word {R[4:0],G[5:0],B[4:0]}.
- `frame_done` out 1: one-cycle pulse at the end of each captured frame.
- `overflow` out 1: sticky flag, set on any dropped word.
- `frame_count` out 8: captured frames, wraps 255→0.

## Operation
- Input stage: `cam_vsync`, `cam_href` and `cam_data` are registered once (`*_r`). All logic uses the registered copies. Edges are detected against a second delayed copy.
- States:
  - WAIT_FRAME (reset state): wait for a vsync falling edge, then go to SKIP if the skip counter is below `SKIP_FRAMES`, else to CAPTURE.
  - SKIP: on vsync rising edge, increment the skip counter and return to WAIT_FRAME.
  - CAPTURE: pack bytes and write words. On vsync rising edge, pulse `frame_done`, increment `frame_count`, and go to WAIT_FRAME.
  - DROP: entered from CAPTURE when a word finds `full_fifo`=1. Issues no writes. On vsync rising edge, go to WAIT_FRAME with no `frame_done` pulse and no `frame_count` increment.
- Byte pairing:
  - `phase` clears on every href rising edge and toggles on each cycle with `href_r`=1.
  - phase 0 byte is latched as the high byte; the phase 1 byte completes the word {hi, lo}.
  - An unpaired byte at an href falling edge is discarded.
- Counters:
  - `x` (10 bits) counts completed words in a line. It clears on the href rising edge. Words with `x` ≥ `H_ACTIVE` are not written.
  - `y` (9 bits) increments on each href falling edge in CAPTURE and clears on entry to CAPTURE. Lines with `y` ≥ `V_ACTIVE` are not written.
- Full handling: `full_fifo` is checked at the edge that would assert `wr_en`. If full, `wr_en` stays 0, `overflow` is set, and the state becomes DROP. Only `rst` clears `overflow`.
- Simultaneous events:
  - A vsync rising edge in the same cycle as a completed word: the word is discarded.
  - `full_fifo`=1 in the same cycle as a vsync rising edge: vsync wins, so the frame is reported done and `overflow` is not set.
- Reset mid-frame: return to WAIT_FRAME with skip counter 0. Capture therefore resumes only after a full vsync cycle plus `SKIP_FRAMES` frames.

## Timing
- Reset values:
  - `wr_en`=0, `dout`=0, `frame_done`=0, `overflow`=0, `frame_count`=0.
  - Internal: state=WAIT_FRAME, skip counter, `x`, `y` and `phase` all 0.
  - Input registers clear to 0.
- Latency: a low byte present on `cam_data` before edge k is registered at k. `wr_en`=1 with `dout` valid during the cycle after edge k+1 (2 edges from pin to strobe).
- `wr_en` is high for exactly one cycle per word, never on consecutive cycles. Maximum rate is one word per 2 PCLK.
- `frame_done` is asserted for the one cycle following the edge that detects the vsync rising edge.
- `dout` holds its last value when `wr_en`=0.

## Structure
- Shared package `cam_pkg`:
  - state encoding `cam_state_t` (WAIT_FRAME=0, SKIP=1, CAPTURE=2, DROP=3);
  - `H_ACTIVE`/`V_ACTIVE` defaults;
  - RGB565 field-slice constants, shared with the VGA stage.
- One sub-module, `sync_edge_det`: the register plus delayed copy for one signal, producing rise/fall pulses. It is instantiated for vsync and href.

## Test plan
- Reset, then 3 frames of 640x480 with `full_fifo`=0 → frames 1–2 are skipped with no `wr_en`. Frame 3 produces exactly 307200 `wr_en` pulses, then one `frame_done`, and `frame_count`=1.
- Byte pair 0xF8,0x1F in a captured line → `dout`=16'hF81F with `wr_en`=1 at edge k+1 after the 0x1F byte was sampled.
- Line of 642 pixels followed by a line with an odd trailing byte → 640 writes for each line. The extra pixels and the unpaired byte are not written.
- `full_fifo`=1 at word 1000 of a frame → no further writes, `overflow`=1, no `frame_done`, and `frame_count` unchanged. The next frame captures normally and `overflow` stays 1.
- `rst` pulsed mid-capture at line 200 → outputs return to reset values the next cycle. The first write follows only a complete vsync cycle plus 2 skipped frames.
- 256 captured frames → `frame_count` wraps to 0 and `frame_done` pulses 256 times.
